// File: rtl/count_seq_ctrl_pkg.sv
// Shared constants and types for the count_seq_ctrl sequencer and its bench.
// The state encoding is fixed so that the state value can be read off a waveform.
package count_seq_ctrl_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/count_seq_step_timer.sv
// Remaining-step counter for the sequencer: loads the requested step count and
// decrements once per count edge, saturating at zero.
module count_seq_step_timer
  import count_seq_ctrl_pkg::*;
#(
  parameter int STEP_W = WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic              dec_i,
  output logic [STEP_W-1:0] rem_o,
  output logic              zero_o,
  output logic              last_o
);

  logic [STEP_W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load_i)                     rem_d = steps_i;
    else if (dec_i && rem_q != '0)  rem_d = rem_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rem_q <= '0;
    else      rem_q <= rem_d;
  end

  assign rem_o  = rem_q;
  assign zero_o = (rem_q == '0);
  assign last_o = (rem_q == STEP_W'(1));

endmodule

// File: rtl/syn_up_down_counter.sv
// Synchronous 4-bit up/down counter with parallel load and synchronous active-high reset.
// Load has priority over counting; all values wrap modulo 2^WIDTH.
module syn_up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             mode,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] cnt_q;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (load) cnt_q <= in;
    else if (mode) cnt_q <= cnt_q + 1'b1;
    else           cnt_q <= cnt_q - 1'b1;
  end

  assign out = cnt_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Command sequencer driving an up/down counter: load a preset, count N steps,
// then hold the result by reloading the counter output and report completion.
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_start,
  input  logic         cmd_mode,
  input  logic [W-1:0] cmd_steps,
  input  logic         abort,
  input  logic [W-1:0] ctr_out,
  output logic [W-1:0] ctr_in,
  output logic         ctr_load,
  output logic         ctr_mode,
  output logic         busy,
  output logic         done,
  output logic         wrap
);

  state_e       state_q, state_d;
  logic [W-1:0] start_q, start_d;
  logic         mode_q, mode_d;
  logic         wrap_q, wrap_d;

  logic         accept;
  logic         run_edge;
  logic         rem_zero, rem_last;
  logic [W-1:0] rem;

  assign accept   = (state_q == ST_IDLE) && cmd_valid;
  assign run_edge = (state_q == ST_RUN);

  count_seq_step_timer #(.STEP_W(W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .steps_i (cmd_steps),
    .dec_i   (run_edge),
    .rem_o   (rem),
    .zero_o  (rem_zero),
    .last_o  (rem_last)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    mode_d  = mode_q;
    wrap_d  = wrap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          start_d = cmd_start;
          mode_d  = cmd_mode;
          wrap_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = rem_zero ? ST_DONE : ST_RUN;
      ST_RUN: begin
        // ctr_out is the value about to change on this edge.
        if ((mode_q == MODE_UP   && ctr_out == {W{1'b1}}) ||
            (mode_q == MODE_DOWN && ctr_out == '0))
          wrap_d = 1'b1;
        if (abort || rem_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    ctr_load  = 1'b1;
    ctr_in    = ctr_out;
    ctr_mode  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: begin
        ctr_in = start_q;
        busy   = 1'b1;
      end
      ST_RUN: begin
        ctr_load = 1'b0;
        ctr_mode = mode_q;
        busy     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // wrap stays visible from the done pulse until the next accept clears it.
  assign wrap = wrap_q;

endmodule
